fifo_stream_reader: RTL and testbench

- Read-side master for the team's synchronous FIFOs (`data_fifo` / `flit_buffer` style): one-cycle registered read latency, `empty` flag.
- Pops words from the FIFO by driving `fifo_rd_en` and captures `fifo_dout` one cycle later.
- Re-presents the words as a registered valid/ready stream through a 2-entry output buffer, so downstream backpressure never loses a word.
- Sits between a router/core input FIFO and its consumer logic.

---
 rtl/fifo_stream_reader.sv | 122 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side master for one-cycle-latency synchronous FIFOs, re-presented as a
// registered valid/ready stream through a 2-entry buffer. Optional stats: STREAM_RD_STATS_EN.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  occ_t                  occ_q, occ_d;
  logic                  inflight_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  pop;
  logic [1:0]            cnt;
  logic [1:0]            pending;

  assign cnt     = occ_q;
  assign pop     = out_valid_q & out_ready;
  // Occupancy after this edge if nothing new were issued; bounded to 0..2.
  assign pending = cnt + {1'b0, inflight_q} - {1'b0, pop};

  assign fifo_rd_en = rst_n & ~flush & ~fifo_empty & (pending < 2'd2);
  assign out_valid  = out_valid_q;
  assign out_data   = head_q;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case ({pop, inflight_q})
        2'b01: begin
          if (occ_q == OCC_EMPTY) begin
            head_d = fifo_dout;
            occ_d  = OCC_ONE;
          end else begin
            skid_d = fifo_dout;
            occ_d  = OCC_TWO;
          end
        end
        2'b10: begin
          if (occ_q == OCC_TWO) begin
            head_d = skid_q;
            occ_d  = OCC_ONE;
          end else begin
            occ_d  = OCC_EMPTY;
          end
        end
        2'b11: begin
          if (occ_q == OCC_TWO) begin
            head_d = skid_q;
            skid_d = fifo_dout;
          end else begin
            head_d = fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q       <= OCC_EMPTY;
      inflight_q  <= 1'b0;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
    end else begin
      occ_q       <= occ_d;
      inflight_q  <= fifo_rd_en;
      out_valid_q <= (occ_d != OCC_EMPTY);
      head_q      <= head_d;
      skid_q      <= skid_d;
    end
  end

`ifdef STREAM_RD_STATS_EN
  logic [CNT_WIDTH-1:0] words_q;
  logic [CNT_WIDTH-1:0] stall_q;

  // Saturating; flush leaves history intact, and a pop discarded by flush is not counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      if (pop && !flush && (words_q != '1))
        words_q <= words_q + 1'b1;
      if (out_valid_q && !out_ready && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign words_out    = words_q;
  assign stall_cycles = stall_q;
`else
  assign words_out    = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench: behavioural FIFO plus a queue-based reference of the stream buffer.
module tb_fifo_stream_reader;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n, flush, fifo_empty, fifo_rd_en, out_valid, out_ready;
  logic [DW-1:0] fifo_dout, out_data;
  logic [CW-1:0] words_out, stall_cycles;

  fifo_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .words_out(words_out),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [DW-1:0] fq[$];     // FIFO contents
  logic [DW-1:0] bq[$];     // words held by the reader, head first
  bit            m_inflight;
  bit            m_zero_data;
  int unsigned   m_words, m_stall;
  int unsigned   rd_count;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock: drive inputs, check at negedge, then advance FIFO and model after posedge.
  task automatic step(input bit rst, input bit fl, input bit rdy);
    bit            rd_s, pop_s, exp_rd;
    int            pend;
    logic [DW-1:0] cap;
    rst_n = rst; flush = fl; out_ready = rdy;
    @(negedge clk);
    pop_s = (bq.size() != 0) && rdy;
    pend  = bq.size() + int'(m_inflight) - int'(pop_s);
    exp_rd = rst && !fl && (fq.size() != 0) && (pend < 2);
    chk("rd_en", {31'b0, fifo_rd_en}, {31'b0, exp_rd});
    chk("valid", {31'b0, out_valid}, {31'b0, bq.size() != 0});
    if (bq.size() != 0) chk("data", out_data, bq[0]);
    else if (m_zero_data) chk("data_rst", out_data, '0);
`ifdef STREAM_RD_STATS_EN
    chk("words_out", {16'b0, words_out}, m_words);
    chk("stall", {16'b0, stall_cycles}, m_stall);
`else
    chk("words_out", {16'b0, words_out}, '0);
    chk("stall", {16'b0, stall_cycles}, '0);
`endif
    rd_s = fifo_rd_en;
    cap  = fifo_dout;
    @(posedge clk);
    #1;
    if (!rst) begin
      bq.delete(); m_inflight = 0; m_zero_data = 1; m_words = 0; m_stall = 0;
    end else begin
      if (bq.size() != 0 && !rdy && m_stall < 65535) m_stall++;
      if (fl) begin
        bq.delete(); m_inflight = 0;
      end else begin
        if (pop_s) begin
          void'(bq.pop_front());
          if (m_words < 65535) m_words++;
        end
        if (m_inflight) begin
          bq.push_back(cap); m_zero_data = 0;
        end
        m_inflight = rd_s;
      end
    end
    if (rd_s) begin
      rd_count++;
      if (fq.size() == 0) chk("underflow", 1, 0);
      else fifo_dout = fq.pop_front();
    end
    fifo_empty = (fq.size() == 0);
  endtask

  initial begin
    logic [DW-1:0] w;
    rst_n = 0; flush = 0; out_ready = 0; fifo_empty = 1; fifo_dout = '0;
    m_inflight = 0; m_zero_data = 1; m_words = 0; m_stall = 0; rd_count = 0;
    @(posedge clk); #1;

    // Prefilled FIFO, reader released from reset with ready high.
    push(32'h11); push(32'h22); push(32'h33);
    step(0, 0, 1); step(0, 0, 1);
    rd_count = 0;
    repeat (8) step(1, 0, 1);
    chk("three_reads", rd_count, 3);

    // Backpressure: only two reads, head held while stalled.
    for (int unsigned i = 0; i < 8; i++) push($urandom);
    rd_count = 0;
    repeat (13) step(1, 0, 0);
    chk("two_reads", rd_count, 2);
    repeat (14) step(1, 0, 1);

    // Alternating ready.
    for (int unsigned i = 0; i < 6; i++) push($urandom);
    for (int unsigned i = 0; i < 20; i++) step(1, 0, i[0] == 1'b0);

    // Flush with one held word and a read in flight.
    push(32'h55);
    repeat (3) step(1, 0, 0);
    push(32'h66);
    step(1, 0, 0);
    step(1, 1, 0);
    push(32'hAB);
    repeat (4) step(1, 0, 0);
    chk("after_flush", out_data, 32'hAB);
    repeat (3) step(1, 0, 1);

    // Reset for one cycle with a read in flight.
    for (int unsigned i = 0; i < 4; i++) push($urandom);
    step(1, 0, 1);
    step(0, 0, 1);
    repeat (8) step(1, 0, 1);

    // Random traffic, flushes and resets.
    for (int unsigned i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) push($urandom);
      step($urandom_range(0, 49) != 0, $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
    end
    repeat (10) step(1, 0, 1);
    chk("drained", {31'b0, out_valid}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
